// File: rtl/hazard_pkg.sv
// Shared constants, hazard cause encoding and counter sizing for the
// decode-stage hazard scoreboard.
package hazard_pkg;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'd0,
      CAUSE_EX_RAW = 2'd1,
      CAUSE_BR_RAW = 2'd2
   } cause_e;

   // Width needed to hold the longest producer latency (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned alu_lat,
                                             input int unsigned load_lat);
      int unsigned max_lat;
      max_lat = (alu_lat > load_lat) ? alu_lat : load_lat;
      return (max_lat < 2) ? 1 : $clog2(max_lat + 1);
   endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One register's pending-result countdown: a load restarts it, otherwise it
// counts down to zero and stays there.
module hazard_sb_entry #(
   parameter int unsigned CW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt
);

   // A reload takes priority over the decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load_en) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage hazard detector built on a per-register countdown scoreboard;
// drives stall, ID/EX bubble and IF/ID flush and counts stalled cycles.
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned ALU_LAT  = 1,
   parameter int unsigned LOAD_LAT = 2,
   parameter int unsigned EX_SLACK = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [5:0]        id_op,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_wr,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_is_load,
   input  logic              id_branch_taken,
   output logic              stall,
   output logic              flush_idex,
   output logic              flush_ifid,
   output logic [1:0]        hazard_cause,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int unsigned CW = cnt_width(ALU_LAT, LOAD_LAT);

   logic [CW-1:0] cnt [NUM_REGS];
   logic [CW-1:0] issue_lat;
   logic [CW-1:0] rs_cnt;
   logic [CW-1:0] rt_cnt;
   logic          is_branch;
   logic          rs_ok;
   logic          rt_ok;
   logic          issue;

   assign cnt[0]    = '0;
   assign issue_lat = id_is_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);
   assign issue     = id_valid && !stall && id_wr && (id_dst != '0);

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      hazard_sb_entry #(.CW(CW)) u_entry (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_en  (issue && (id_dst == REG_AW'(r))),
         .load_val (issue_lat),
         .cnt      (cnt[r])
      );
   end

   // Branches compare in ID and need the value now; EX consumers can forward.
   always_comb begin
      is_branch    = (id_op == OP_BEQ) || (id_op == OP_BNE);
      rs_cnt       = cnt[id_rs];
      rt_cnt       = cnt[id_rt];
      rs_ok        = 1'b1;
      rt_ok        = 1'b1;
      stall        = 1'b0;
      flush_idex   = 1'b0;
      flush_ifid   = 1'b0;
      hazard_cause = CAUSE_NONE;

      if (id_uses_rs && (id_rs != '0)) begin
         rs_ok = is_branch ? (rs_cnt == '0) : (32'(rs_cnt) <= EX_SLACK);
      end
      if (id_uses_rt && (id_rt != '0)) begin
         rt_ok = is_branch ? (rt_cnt == '0) : (32'(rt_cnt) <= EX_SLACK);
      end

      // Outputs are forced quiet while reset is held, whatever the inputs do.
      if (rst_n && id_valid) begin
         if (!(rs_ok && rt_ok)) begin
            stall        = 1'b1;
            flush_idex   = 1'b1;
            hazard_cause = is_branch ? CAUSE_BR_RAW : CAUSE_EX_RAW;
         end else if ((is_branch && id_branch_taken) || (id_op == OP_J)) begin
            flush_ifid = 1'b1;
         end
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the ID-stage hazard detector.
- Replaces fixed one-stage compare logic with a per-register countdown scoreboard. Arbitrary producer latencies (ALU, load, multi-cycle) resolve without per-stage comparators.
- Sits beside the decode stage. Drives pipeline stall, ID/EX bubble and IF/ID flush.
- Keeps a saturating stall-cycle counter and reports the cause of each stall.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 is never pending.
- REG_AW, 5, register index width.
- ALU_LAT, 1, cycles after issue until an ALU result is forwardable to ID.
- LOAD_LAT, 2, cycles after issue until a load result is forwardable to ID.
- EX_SLACK, 1, remaining count tolerated by a consumer that reads operands in EX via forwarding.
- CNT_W, 16, stall statistics counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_op  in  6  opcode of ID instruction
- id_rs  in  REG_AW  source register 1
- id_rt  in  REG_AW  source register 2
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_wr  in  1  ID instruction writes a register
- id_dst  in  REG_AW  destination register
- id_is_load  in  1  ID instruction is a load
- id_branch_taken  in  1  ID comparator result for beq/bne
- stall  out  1  hold PC and IF/ID
- flush_idex  out  1  insert bubble into ID/EX
- flush_ifid  out  1  squash IF/ID
- hazard_cause  out  2  0 none, 1 EX-consumer RAW, 2 branch-operand RAW
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset:
  - Asynchronous on rst_n low: all scoreboard counters and stall_cycles go to 0.
  - stall, flush_idex, flush_ifid and hazard_cause read 0 while reset is held.
  - Reset mid-operation discards all pending state immediately.
- State:
  - One counter per register, cnt[r], width clog2(max(ALU_LAT, LOAD_LAT)+1).
  - cnt[0] is constant 0.
- Branch classification: id_op 000100 (beq) and 000101 (bne). Branches read operands in ID. All other consumers read in EX.
- Operand readiness:
  - Branch consumer: operand is ready when cnt == 0.
  - EX consumer: operand is ready when cnt <= EX_SLACK.
  - Only operands with the matching id_uses_* bit set are checked.
  - Register 0 is always ready.
- stall (combinational):
  - Asserted when id_valid is high and any used operand is not ready.
  - flush_idex = stall.
  - hazard_cause is 2 if the stalled instruction is a branch, else 1. It is 0 when not stalled.
- flush_ifid (combinational):
  - Asserted when id_valid and not stall and either: (branch with id_branch_taken) or (id_op == 000010, jump).
  - stall has priority: flush_ifid is 0 whenever stall is 1. No value is held over from a previous cycle.
- Issue:
  - Occurs when id_valid and not stall.
  - If id_wr and id_dst != 0, then cnt[id_dst] <= (id_is_load ? LOAD_LAT : ALU_LAT) at the next clk edge.
- Decrement: every other nonzero counter decrements by 1 each cycle. A stalled instruction does not issue.
- Simultaneous issue and decrement on the same register: the issue load wins (a WAW reload restarts the countdown).
- Latency: counters update one cycle after issue. Outputs are purely combinational from the counters and current inputs, with zero cycle latency.
- stall_cycles: increments on every cycle with stall = 1. It saturates at all-ones and never wraps.
- Default latencies reproduce the legacy rules:
  - load-use: 1 bubble.
  - ALU-then-branch: 1 bubble.
  - load-then-branch: 2 bubbles.

Decomposition:
- Package hazard_pkg holds:
  - opcode constants OP_BEQ, OP_BNE, OP_J;
  - the hazard_cause encoding (CAUSE_NONE, CAUSE_EX_RAW, CAUSE_BR_RAW);
  - the counter-width function.
- Sub-module hazard_sb_entry: one register's countdown counter with load/decrement/reset. Instantiate it NUM_REGS-1 times through a generate loop.

Test Plan:
- Reset: rst_n low for 3 cycles with random inputs -> stall=0, flush_ifid=0, stall_cycles=0. A consumer of r5 issued right after reset does not stall.
- Load-use: lw r8 issues, next cycle add reads r8 -> stall=1, flush_idex=1, cause=1 for exactly 1 cycle. add issues the following cycle. stall_cycles=1.
- Branch after load: lw r9, then beq r9,r0 -> stall for 2 cycles with cause=2. Third cycle: branch resolves; with id_branch_taken=1, flush_ifid=1 and stall=0.
- Branch after ALU: add r3, then bne r3,r4 taken -> 1 stall cycle with flush_ifid=0, then flush_ifid=1 for 1 cycle.
- WAW and r0:
  - lw r7 then add r7 (independent sources), then an EX consumer of r7 -> the consumer sees cnt reloaded to ALU_LAT and does not stall.
  - Writes to r0 never cause a stall.
- Saturation and jump:
  - Set CNT_W=3 and force 10 stall cycles -> stall_cycles holds at 7.
  - Jump (000010) with no hazard -> flush_ifid=1, stall=0.
